// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: bus command encoding, client ids, owner-table entry.
`ifndef XLEN
`define XLEN 32
`endif

package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_t;

  typedef enum logic {
    CLIENT_ICACHE = 1'b0,
    CLIENT_DCACHE = 1'b1
  } mem_client_t;

  typedef struct packed {
    logic        valid;
    mem_client_t owner;
  } owner_entry_t;

  localparam int TAG_W = 4;
  // Instruction fetches always move a full 64-bit line word.
  localparam logic [1:0] ICACHE_FETCH_SIZE = 2'd3;

endpackage

// File: rtl/mem_tag_table.sv
// Owner table for outstanding load tags: allocate on accept, retire on data return.
// Tracks the live-entry count and a sticky error for orphan returns or tag reuse.
import mem_bus_arbiter_pkg::*;

module mem_tag_table #(
  parameter int NUM_TAGS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  mem_client_t      alloc_owner,
  input  logic [TAG_W-1:0] ret_tag,
  output logic             ret_hit,
  output mem_client_t      ret_owner,
  output logic [4:0]       outstanding,
  output logic             error
);

  owner_entry_t tbl [NUM_TAGS];
  owner_entry_t ret_entry;
  owner_entry_t alloc_entry;
  logic         post_reset;
  logic         ret_present;
  logic         same_tag;
  logic         alloc_live;
  logic         inc;
  logic         reuse_err;
  logic         miss_err;

  assign ret_entry   = tbl[ret_tag];
  assign alloc_entry = tbl[alloc_tag];
  assign ret_present = (ret_tag != '0);
  assign ret_hit     = ret_present && ret_entry.valid;
  assign ret_owner   = ret_entry.owner;

  // An entry retiring on this edge is free for reallocation, so it is neither reuse nor a count change.
  assign same_tag   = ret_hit && (ret_tag == alloc_tag);
  assign alloc_live = alloc_entry.valid && !same_tag;
  assign inc        = alloc_en && !alloc_live;
  assign reuse_err  = alloc_en && alloc_live;
  assign miss_err   = ret_present && !ret_entry.valid && !post_reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        tbl[i] <= '{valid: 1'b0, owner: CLIENT_ICACHE};
      end
      outstanding <= '0;
      error       <= 1'b0;
      post_reset  <= 1'b1;
    end else begin
      if (ret_hit) tbl[ret_tag].valid <= 1'b0;
      if (alloc_en) begin
        tbl[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
        post_reset     <= 1'b0;
      end
      outstanding <= outstanding + 5'(inc) - 5'(ret_hit);
      if (reuse_err || miss_err) error <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates icache/dcache onto the single memory bus and steers accept/return tags back.
// ARB_STARVE_GUARD_EN builds the icache starvation counter; otherwise dcache always wins.
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        icache2mem_command,
  input  logic [`XLEN-1:0]  icache2mem_addr,
  input  logic [1:0]        dcache2mem_command,
  input  logic [`XLEN-1:0]  dcache2mem_addr,
  input  logic [63:0]       dcache2mem_data,
  input  logic [1:0]        dcache2mem_size,
  output logic [1:0]        proc2mem_command,
  output logic [`XLEN-1:0]  proc2mem_addr,
  output logic [63:0]       proc2mem_data,
  output logic [1:0]        proc2mem_size,
  input  logic [3:0]        mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [3:0]        mem2proc_tag,
  output logic [3:0]        mem2icache_response,
  output logic [3:0]        mem2dcache_response,
  output logic [3:0]        mem2icache_tag,
  output logic [3:0]        mem2dcache_tag,
  output logic [63:0]       mem2icache_data,
  output logic [63:0]       mem2dcache_data,
  output logic [4:0]        arb_outstanding,
  output logic              arb_error
);

  logic        live;
  logic        icache_req;
  logic        dcache_req;
  logic        force_icache;
  logic        grant_icache;
  logic        grant_dcache;
  logic        alloc_en;
  logic        ret_hit;
  mem_client_t ret_owner;

  assign live       = !reset;
  assign icache_req = (icache2mem_command != BUS_NONE);
  assign dcache_req = (dcache2mem_command != BUS_NONE);

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign force_icache = (32'(starve_cnt) >= STARVE_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) starve_cnt <= '0;
    else if (icache_req && !grant_icache) begin
      if (starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
    end else starve_cnt <= '0;
  end
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = 32'(STARVE_LIMIT);
  assign force_icache = 1'b0;
`endif

  assign grant_dcache = dcache_req && !(force_icache && icache_req);
  assign grant_icache = icache_req && !grant_dcache;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = '0;
    if (live && grant_dcache) begin
      proc2mem_command = dcache2mem_command;
      proc2mem_addr    = dcache2mem_addr;
      proc2mem_data    = dcache2mem_data;
      proc2mem_size    = dcache2mem_size;
    end else if (live && grant_icache) begin
      proc2mem_command = icache2mem_command;
      proc2mem_addr    = icache2mem_addr;
      proc2mem_size    = ICACHE_FETCH_SIZE;
    end
  end

  assign mem2icache_response = (live && grant_icache) ? mem2proc_response : 4'd0;
  assign mem2dcache_response = (live && grant_dcache) ? mem2proc_response : 4'd0;
  assign mem2icache_tag  = (live && ret_hit && ret_owner == CLIENT_ICACHE) ? mem2proc_tag : 4'd0;
  assign mem2dcache_tag  = (live && ret_hit && ret_owner == CLIENT_DCACHE) ? mem2proc_tag : 4'd0;
  assign mem2icache_data = live ? mem2proc_data : 64'd0;
  assign mem2dcache_data = live ? mem2proc_data : 64'd0;

  assign alloc_en = live && (mem2proc_response != 4'd0) && (proc2mem_command == BUS_LOAD);

  mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_response),
    .alloc_owner (grant_dcache ? CLIENT_DCACHE : CLIENT_ICACHE),
    .ret_tag     (mem2proc_tag),
    .ret_hit     (ret_hit),
    .ret_owner   (ret_owner),
    .outstanding (arb_outstanding),
    .error       (arb_error)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; expectations follow the guard macro setting.
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_bus_arbiter;

  logic              clock = 1'b0;
  logic              reset;
  logic [1:0]        icmd, dcmd, dsize;
  logic [`XLEN-1:0]  iaddr, daddr;
  logic [63:0]       ddata, mdata;
  logic [3:0]        mresp, mtag;
  logic [1:0]        p_cmd, p_size;
  logic [`XLEN-1:0]  p_addr;
  logic [63:0]       p_data, i_data, d_data;
  logic [3:0]        i_resp, d_resp, i_tag, d_tag;
  logic [4:0]        outst;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;
  bit guard;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .NUM_TAGS(16)) dut (
    .clock(clock), .reset(reset),
    .icache2mem_command(icmd), .icache2mem_addr(iaddr),
    .dcache2mem_command(dcmd), .dcache2mem_addr(daddr),
    .dcache2mem_data(ddata), .dcache2mem_size(dsize),
    .proc2mem_command(p_cmd), .proc2mem_addr(p_addr),
    .proc2mem_data(p_data), .proc2mem_size(p_size),
    .mem2proc_response(mresp), .mem2proc_data(mdata), .mem2proc_tag(mtag),
    .mem2icache_response(i_resp), .mem2dcache_response(d_resp),
    .mem2icache_tag(i_tag), .mem2dcache_tag(d_tag),
    .mem2icache_data(i_data), .mem2dcache_data(d_data),
    .arb_outstanding(outst), .arb_error(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    icmd = 2'd0; iaddr = '0; dcmd = 2'd0; daddr = '0; ddata = '0; dsize = 2'd0;
    mresp = 4'd0; mdata = '0; mtag = 4'd0;
  endtask

  initial begin
`ifdef ARB_STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    clear_inputs();
    reset = 1'b1;

    // Outputs held quiet under reset even with live requests
    @(negedge clock); icmd = 2'd1; iaddr = 'h100; mresp = 4'd3; #1;
    chk("rst_cmd",   64'(p_cmd), 64'd0);
    chk("rst_iresp", 64'(i_resp), 64'd0);
    chk("rst_outst", 64'(outst), 64'd0);
    chk("rst_err",   64'(err), 64'd0);

    @(negedge clock); clear_inputs(); reset = 1'b0; #1;
    chk("idle_cmd",  64'(p_cmd), 64'd0);
    chk("idle_addr", 64'(p_addr), 64'd0);

    // Icache load alone, tag 3
    @(negedge clock); icmd = 2'd1; iaddr = 'h100; mresp = 4'd3; mdata = 64'h1234_5678_9abc_def0; #1;
    chk("t1_iresp", 64'(i_resp), 64'd3);
    chk("t1_dresp", 64'(d_resp), 64'd0);
    chk("t1_cmd",   64'(p_cmd), 64'd1);
    chk("t1_addr",  64'(p_addr), 64'h100);
    chk("t1_idata", i_data, 64'h1234_5678_9abc_def0);
    @(negedge clock); clear_inputs(); #1;
    chk("t1_outst1", 64'(outst), 64'd1);
    @(negedge clock); mtag = 4'd3; #1;
    chk("t1_itag", 64'(i_tag), 64'd3);
    chk("t1_dtag", 64'(d_tag), 64'd0);
    @(negedge clock); clear_inputs(); #1;
    chk("t1_outst0", 64'(outst), 64'd0);
    chk("t1_err",    64'(err), 64'd0);

    // Both load, dcache wins, tag 5
    @(negedge clock); icmd = 2'd1; iaddr = 'h100; dcmd = 2'd1; daddr = 'h200; mresp = 4'd5; #1;
    chk("t2_dresp", 64'(d_resp), 64'd5);
    chk("t2_iresp", 64'(i_resp), 64'd0);
    chk("t2_addr",  64'(p_addr), 64'h200);
    @(negedge clock); clear_inputs(); mtag = 4'd5; #1;
    chk("t2_dtag", 64'(d_tag), 64'd5);
    chk("t2_itag", 64'(i_tag), 64'd0);
    @(negedge clock); clear_inputs(); #1;
    chk("t2_outst", 64'(outst), 64'd0);

    // Tag 9 retires to dcache while reallocated to icache on the same edge
    @(negedge clock); dcmd = 2'd1; daddr = 'h900; mresp = 4'd9; #1;
    @(negedge clock); clear_inputs(); #1;
    chk("t5_outst_a", 64'(outst), 64'd1);
    @(negedge clock); icmd = 2'd1; iaddr = 'h940; mresp = 4'd9; mtag = 4'd9; #1;
    chk("t5_dtag",  64'(d_tag), 64'd9);
    chk("t5_itag",  64'(i_tag), 64'd0);
    chk("t5_iresp", 64'(i_resp), 64'd9);
    @(negedge clock); clear_inputs(); #1;
    chk("t5_outst_b", 64'(outst), 64'd1);
    chk("t5_err",     64'(err), 64'd0);
    @(negedge clock); mtag = 4'd9; #1;
    chk("t5_itag2", 64'(i_tag), 64'd9);
    chk("t5_dtag2", 64'(d_tag), 64'd0);
    @(negedge clock); clear_inputs(); #1;
    chk("t5_outst_c", 64'(outst), 64'd0);

    // Store accept allocates nothing; orphan tag 7 is dropped and flagged
    @(negedge clock); dcmd = 2'd2; daddr = 'h700; ddata = 64'hdead_beef; dsize = 2'd3; mresp = 4'd7; #1;
    chk("t3_dresp", 64'(d_resp), 64'd7);
    chk("t3_cmd",   64'(p_cmd), 64'd2);
    chk("t3_data",  p_data, 64'hdead_beef);
    @(negedge clock); clear_inputs(); #1;
    chk("t3_outst", 64'(outst), 64'd0);
    @(negedge clock); mtag = 4'd7; #1;
    chk("t3_itag", 64'(i_tag), 64'd0);
    chk("t3_dtag", 64'(d_tag), 64'd0);
    @(negedge clock); clear_inputs(); #1;
    chk("t3_err", 64'(err), 64'd1);

    // Starvation: dcache holds the bus, icache keeps asking (memory rejects)
    for (int k = 0; k < 6; k++) begin
      @(negedge clock); icmd = 2'd1; iaddr = 'h300; dcmd = 2'd1; daddr = 'h400; #1;
      chk($sformatf("starve_addr_%0d", k), 64'(p_addr), (guard && k == 4) ? 64'h300 : 64'h400);
    end
    @(negedge clock); clear_inputs(); #1;

    // Reset mid-flight with three outstanding loads
    @(negedge clock); icmd = 2'd1; iaddr = 'h10; mresp = 4'd1; #1;
    @(negedge clock); mresp = 4'd2; #1;
    @(negedge clock); mresp = 4'd4; #1;
    @(negedge clock); clear_inputs(); #1;
    chk("t6_outst3", 64'(outst), 64'd3);
    @(negedge clock); icmd = 2'd1; reset = 1'b1; #1;
    chk("t6_outst0", 64'(outst), 64'd0);
    chk("t6_errclr", 64'(err), 64'd0);
    chk("t6_cmd",    64'(p_cmd), 64'd0);
    @(negedge clock); clear_inputs(); reset = 1'b0; mtag = 4'd2; #1;
    chk("t6_itag", 64'(i_tag), 64'd0);
    chk("t6_dtag", 64'(d_tag), 64'd0);
    @(negedge clock); clear_inputs(); #1;
    chk("t6_err",   64'(err), 64'd0);
    chk("t6_outst", 64'(outst), 64'd0);
    // After a fresh allocation, orphan returns are flagged again
    @(negedge clock); icmd = 2'd1; mresp = 4'd6; #1;
    @(negedge clock); clear_inputs(); mtag = 4'd11; #1;
    @(negedge clock); clear_inputs(); #1;
    chk("t6_err_rearm", 64'(err), 64'd1);
    chk("t6_outst1",    64'(outst), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
